// File: rtl/hdlc_pkg.sv
// -----------------------------------------------------------------------------
// hdlc_pkg
// Shared constants, types and CRC helper for the HDLC receive deframer.
//   HDLC_FLAG   : opening/closing flag octet
//   CRC_POLY    : CRC-16/CCITT generator (normal form)
//   CRC_GOOD    : residue left in the reflected CRC register after a good FCS
//   rx_state_t  : deframer state (HUNT / OPEN / DATA)
//   bit_class_t : classification of an arriving line bit
//   rx_err_t    : error flags reported with end-of-frame
// -----------------------------------------------------------------------------
package hdlc_pkg;

  localparam logic [7:0]  HDLC_FLAG = 8'h7E;
  localparam logic [15:0] CRC_POLY  = 16'h1021;
  localparam logic [15:0] CRC_GOOD  = 16'hF0B8;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    OPEN = 2'd1,
    DATA = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    BIT_DATA  = 2'd0,
    BIT_STUFF = 2'd1,
    BIT_FLAG  = 2'd2,
    BIT_ABORT = 2'd3
  } bit_class_t;

  typedef struct packed {
    logic fcs;
    logic short_f;
    logic align;
  } rx_err_t;

  // One serial step of the reflected CRC-16/CCITT. The line sends LSB first,
  // so the register shifts right and uses the bit-reversed polynomial.
  function automatic logic [15:0] crc16_refl_step(input logic [15:0] crc,
                                                  input logic        din);
    logic [15:0] poly_refl;
    logic        fb;
    for (int i = 0; i < 16; i++) begin
      poly_refl[i] = CRC_POLY[15-i];
    end
    fb = crc[0] ^ din;
    crc16_refl_step = {1'b0, crc[15:1]} ^ (fb ? poly_refl : 16'h0000);
  endfunction

endpackage

// File: rtl/hdlc_crc16_bit.sv
// -----------------------------------------------------------------------------
// hdlc_crc16_bit
// Combinational single-bit update of the reflected CRC-16/CCITT register.
// Ports:
//   crc_i [15:0] : current CRC register
//   bit_i        : data bit being absorbed (line order, LSB of byte first)
//   crc_o [15:0] : updated CRC register
// -----------------------------------------------------------------------------
module hdlc_crc16_bit
  import hdlc_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  assign crc_o = crc16_refl_step(crc_i, bit_i);

endmodule

// File: rtl/hdlc_rx_deframer.sv
// -----------------------------------------------------------------------------
// hdlc_rx_deframer
// Serial HDLC receive front end: flag hunt, zero-bit destuffing, abort
// detection and LSB-first byte assembly with frame markers.
//
// Optional build macro: HDLC_RX_FCS_CHECK_EN enables the CRC-16/CCITT check
// reported in rx_err.fcs; without it rx_err.fcs is tied low.
//
// Ports:
//   clk_i       : system clock
//   rst_n_i     : asynchronous active-low reset
//   rx_en       : receiver enable, low forces HUNT and clears counters
//   rx_bit_vld  : strobe, rx carries a valid line bit
//   rx          : serial line bit
//   shiftreg    : last 8 raw line bits, newest in bit 7
//   flag_det    : pulse, flag received (any state)
//   rx_abort    : pulse, abort seen inside a frame
//   rx_data     : assembled byte, first line bit in bit 0
//   rx_data_vld : pulse, rx_data updated
//   rx_sof      : with rx_data_vld, first byte of the frame
//   rx_eof      : pulse, frame closed by a flag
//   rx_err      : with rx_eof, {fcs, short, align}
// -----------------------------------------------------------------------------
module hdlc_rx_deframer
  import hdlc_pkg::*;
#(
  parameter int unsigned MIN_FRAME_BYTES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_en,
  input  logic       rx_bit_vld,
  input  logic       rx,
  output logic [7:0] shiftreg,
  output logic       flag_det,
  output logic       rx_abort,
  output logic [7:0] rx_data,
  output logic       rx_data_vld,
  output logic       rx_sof,
  output logic       rx_eof,
  output logic [2:0] rx_err
);

  localparam logic [7:0] MIN_BYTES_C = 8'(MIN_FRAME_BYTES);

  rx_state_t  state_r;
  rx_state_t  state_nxt_s;
  bit_class_t cls_s;

  logic       step_s;
  logic       is_flag_s;
  logic       is_abort_s;
  logic       is_data_s;
  logic       commit_s;
  logic       byte_done_s;
  logic       fcs_err_s;

  logic [2:0] ones_cnt_r;
  logic [2:0] dly_cnt_r;
  logic [2:0] bit_cnt_r;
  logic [6:0] dly_r;
  logic [6:0] byte_r;
  logic [7:0] byte_cnt_r;
  logic [7:0] byte_val_s;

  logic       flag_det_nxt_s;
  logic       rx_abort_nxt_s;
  logic       rx_eof_nxt_s;
  logic       rx_sof_nxt_s;
  rx_err_t    err_nxt_s;

  assign step_s = rx_en & rx_bit_vld;

  // Classify the arriving line bit from the run of ones preceding it.
  always_comb begin
    cls_s = BIT_DATA;
    if ((ones_cnt_r == 3'd6) && (rx == 1'b0)) begin
      cls_s = BIT_FLAG;
    end else if ((ones_cnt_r >= 3'd6) && (rx == 1'b1)) begin
      cls_s = BIT_ABORT;
    end else if ((ones_cnt_r == 3'd5) && (rx == 1'b0)) begin
      cls_s = BIT_STUFF;
    end else begin
      cls_s = BIT_DATA;
    end
  end

  assign is_flag_s  = step_s && (cls_s == BIT_FLAG);
  assign is_abort_s = step_s && (cls_s == BIT_ABORT);
  assign is_data_s  = step_s && (cls_s == BIT_DATA) && (state_r != HUNT);
  // The delay line holds 7 bits so a closing flag's 0111111 prefix can be
  // dropped; a bit leaves the line for assembly only when it is full.
  assign commit_s    = is_data_s && (dly_cnt_r == 3'd7);
  assign byte_done_s = commit_s && (bit_cnt_r == 3'd7);
  assign byte_val_s  = {dly_r[0], byte_r};

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= HUNT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    if (!rx_en) begin
      state_nxt_s = HUNT;
    end else begin
      case (state_r)
        HUNT: begin
          if (is_flag_s) state_nxt_s = OPEN;
          else           state_nxt_s = HUNT;
        end
        OPEN: begin
          if (is_flag_s)       state_nxt_s = OPEN;
          else if (is_abort_s) state_nxt_s = HUNT;
          else if (commit_s)   state_nxt_s = DATA;
          else                 state_nxt_s = OPEN;
        end
        DATA: begin
          if (is_flag_s)       state_nxt_s = OPEN;
          else if (is_abort_s) state_nxt_s = HUNT;
          else                 state_nxt_s = DATA;
        end
        default: state_nxt_s = HUNT;
      endcase
    end
  end

  // Output decode: next values of the registered pulse outputs.
  always_comb begin
    flag_det_nxt_s = is_flag_s;
    rx_abort_nxt_s = is_abort_s && (state_r == DATA);
    rx_eof_nxt_s   = is_flag_s && (state_r == DATA);
    rx_sof_nxt_s   = byte_done_s && (byte_cnt_r == 8'd0);
    err_nxt_s      = rx_err_t'(3'b000);
    if (rx_eof_nxt_s) begin
      err_nxt_s.fcs     = fcs_err_s;
      err_nxt_s.short_f = (byte_cnt_r < MIN_BYTES_C);
      err_nxt_s.align   = (bit_cnt_r != 3'd0);
    end else begin
      err_nxt_s = rx_err_t'(3'b000);
    end
  end

  // Datapath: raw shifter, ones run, delay line, byte assembly, outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shiftreg    <= 8'h00;
      flag_det    <= 1'b0;
      rx_abort    <= 1'b0;
      rx_data     <= 8'h00;
      rx_data_vld <= 1'b0;
      rx_sof      <= 1'b0;
      rx_eof      <= 1'b0;
      rx_err      <= 3'b000;
      ones_cnt_r  <= 3'd0;
      dly_cnt_r   <= 3'd0;
      bit_cnt_r   <= 3'd0;
      dly_r       <= 7'd0;
      byte_r      <= 7'd0;
      byte_cnt_r  <= 8'd0;
    end else begin
      flag_det    <= flag_det_nxt_s;
      rx_abort    <= rx_abort_nxt_s;
      rx_eof      <= rx_eof_nxt_s;
      rx_err      <= err_nxt_s;
      rx_data_vld <= byte_done_s;
      rx_sof      <= rx_sof_nxt_s;
      if (!rx_en) begin
        ones_cnt_r <= 3'd0;
        dly_cnt_r  <= 3'd0;
        bit_cnt_r  <= 3'd0;
        byte_cnt_r <= 8'd0;
      end else if (rx_bit_vld) begin
        shiftreg   <= {rx, shiftreg[7:1]};
        ones_cnt_r <= rx ? ((ones_cnt_r == 3'd7) ? 3'd7 : ones_cnt_r + 3'd1) : 3'd0;
        if ((cls_s == BIT_FLAG) || (cls_s == BIT_ABORT)) begin
          // Pending delay-line bits are flag/abort prefix, never data.
          dly_cnt_r  <= 3'd0;
          bit_cnt_r  <= 3'd0;
          byte_cnt_r <= 8'd0;
        end else if (is_data_s) begin
          dly_r <= {rx, dly_r[6:1]};
          if (dly_cnt_r != 3'd7) begin
            dly_cnt_r <= dly_cnt_r + 3'd1;
          end
          if (commit_s) begin
            byte_r    <= byte_val_s[7:1];
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (byte_done_s) begin
              rx_data <= byte_val_s;
              if (byte_cnt_r != 8'hFF) begin
                byte_cnt_r <= byte_cnt_r + 8'd1;
              end
            end
          end
        end
      end
    end
  end

`ifdef HDLC_RX_FCS_CHECK_EN
  logic [15:0] crc_r;
  logic [15:0] crc_nxt_s;

  hdlc_crc16_bit u_crc (
    .crc_i (crc_r),
    .bit_i (dly_r[0]),
    .crc_o (crc_nxt_s)
  );

  // CRC register: seeded on every flag, absorbs each committed data bit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      crc_r <= 16'hFFFF;
    end else if (is_flag_s) begin
      crc_r <= 16'hFFFF;
    end else if (commit_s) begin
      crc_r <= crc_nxt_s;
    end else begin
      crc_r <= crc_r;
    end
  end

  // The FCS bytes themselves are absorbed, so a good frame leaves CRC_GOOD.
  assign fcs_err_s = (crc_r != CRC_GOOD);
`else
  assign fcs_err_s = 1'b0;
`endif

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_hdlc_rx_deframer
// Directed bench for hdlc_rx_deframer: bits are sent one per two clocks,
// a monitor logs pulses and bytes, and each scenario task checks the log.
// -----------------------------------------------------------------------------
module tb_hdlc_rx_deframer;

  logic       clk_i;
  logic       rst_n_i;
  logic       rx_en;
  logic       rx_bit_vld;
  logic       rx;
  logic [7:0] shiftreg;
  logic       flag_det;
  logic       rx_abort;
  logic [7:0] rx_data;
  logic       rx_data_vld;
  logic       rx_sof;
  logic       rx_eof;
  logic [2:0] rx_err;

  int checks;
  int errors;
  int tx_ones;

  int n_flag;
  int n_flag_bad;
  int n_abort;
  int n_eof;
  int n_eof_bad;
  logic [7:0] got_data[$];
  logic       got_sof[$];
  logic [2:0] got_err[$];

  hdlc_rx_deframer #(.MIN_FRAME_BYTES(2)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .rx_en       (rx_en),
    .rx_bit_vld  (rx_bit_vld),
    .rx          (rx),
    .shiftreg    (shiftreg),
    .flag_det    (flag_det),
    .rx_abort    (rx_abort),
    .rx_data     (rx_data),
    .rx_data_vld (rx_data_vld),
    .rx_sof      (rx_sof),
    .rx_eof      (rx_eof),
    .rx_err      (rx_err)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Event log sampled on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    if (flag_det) begin
      n_flag <= n_flag + 1;
      if (shiftreg !== 8'h7E) n_flag_bad <= n_flag_bad + 1;
    end
    if (rx_abort) n_abort <= n_abort + 1;
    if (rx_data_vld) begin
      got_data.push_back(rx_data);
      got_sof.push_back(rx_sof);
    end
    if (rx_eof) begin
      n_eof <= n_eof + 1;
      got_err.push_back(rx_err);
      if (!flag_det) n_eof_bad <= n_eof_bad + 1;
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    rx_bit_vld = 1'b1;
    @(posedge clk_i); #1;
    rx_bit_vld = 1'b0;
    @(posedge clk_i); #1;
  endtask

  // Transmitter-side bit stuffing: a zero after five consecutive ones.
  task automatic send_data_bit(input logic b);
    send_bit(b);
    if (b) begin
      tx_ones = tx_ones + 1;
      if (tx_ones == 5) begin
        send_bit(1'b0);
        tx_ones = 0;
      end
    end else begin
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_data_bit(v[i]);
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) send_bit(f[i]);
    tx_ones = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; rx_en = 1'b0; rx_bit_vld = 1'b0; rx = 1'b0;
    #12;
    checks++;
    if ({shiftreg, flag_det, rx_abort, rx_data, rx_data_vld, rx_sof, rx_eof, rx_err} !== 31'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {shiftreg, flag_det, rx_abort, rx_data, rx_data_vld, rx_sof, rx_eof, rx_err});
    end
    @(negedge clk_i); rst_n_i = 1'b1; rx_en = 1'b1;
    @(posedge clk_i); #1;
    idle(2);
    checks++;
    if (shiftreg !== 8'h00 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL after_reset_regs got shiftreg %h rx_data %h exp 00 00", shiftreg, rx_data);
    end
  endtask

  task automatic test_basic_frame();
    int f0, a0, e0, d0, r0;
    f0 = n_flag; a0 = n_abort; e0 = n_eof; d0 = got_data.size(); r0 = got_err.size();
    send_flag(); send_byte(8'hA5); send_byte(8'h3C); send_flag(); idle(2);
    checks++;
    if (n_flag - f0 != 2) begin errors++; $display("FAIL basic_nflag got %0d exp 2", n_flag - f0); end
    checks++;
    if (n_flag_bad != 0) begin errors++; $display("FAIL basic_flag_shiftreg got %0d bad exp 0", n_flag_bad); end
    checks++;
    if (got_data.size() - d0 != 2) begin errors++; $display("FAIL basic_nbytes got %0d exp 2", got_data.size() - d0); end
    checks++;
    if (got_data[d0] !== 8'hA5 || got_sof[d0] !== 1'b1) begin
      errors++; $display("FAIL basic_byte0 got %h sof %b exp a5 sof 1", got_data[d0], got_sof[d0]);
    end
    checks++;
    if (got_data[d0+1] !== 8'h3C || got_sof[d0+1] !== 1'b0) begin
      errors++; $display("FAIL basic_byte1 got %h sof %b exp 3c sof 0", got_data[d0+1], got_sof[d0+1]);
    end
    checks++;
    if (n_eof - e0 != 1 || n_eof_bad != 0) begin
      errors++; $display("FAIL basic_eof got %0d (bad %0d) exp 1 (bad 0)", n_eof - e0, n_eof_bad);
    end
    checks++;
    if (got_err[r0] !== 3'b000) begin errors++; $display("FAIL basic_err got %b exp 000", got_err[r0]); end
    checks++;
    if (n_abort - a0 != 0) begin errors++; $display("FAIL basic_abort got %0d exp 0", n_abort - a0); end
  endtask

  task automatic test_stuffing();
    int f0, a0, e0, d0, r0;
    f0 = n_flag; a0 = n_abort; e0 = n_eof; d0 = got_data.size(); r0 = got_err.size();
    send_flag(); send_byte(8'h1F); send_byte(8'hFF); send_flag(); idle(2);
    checks++;
    if (got_data.size() - d0 != 2) begin errors++; $display("FAIL stuff_nbytes got %0d exp 2", got_data.size() - d0); end
    checks++;
    if (got_data[d0] !== 8'h1F || got_data[d0+1] !== 8'hFF) begin
      errors++; $display("FAIL stuff_bytes got %h %h exp 1f ff", got_data[d0], got_data[d0+1]);
    end
    checks++;
    if (n_flag - f0 != 2 || n_abort - a0 != 0) begin
      errors++; $display("FAIL stuff_spurious got flags %0d aborts %0d exp 2 0", n_flag - f0, n_abort - a0);
    end
    checks++;
    if (n_eof - e0 != 1 || got_err[r0] !== 3'b000) begin
      errors++; $display("FAIL stuff_eof got %0d err %b exp 1 000", n_eof - e0, got_err[r0]);
    end
  endtask

  task automatic test_abort();
    int f0, a0, e0, d0, r0;
    f0 = n_flag; a0 = n_abort; e0 = n_eof; d0 = got_data.size(); r0 = got_err.size();
    send_flag(); send_byte(8'h55);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    tx_ones = 0;
    idle(2);
    checks++;
    if (n_abort - a0 != 1) begin errors++; $display("FAIL abort_count got %0d exp 1", n_abort - a0); end
    checks++;
    if (n_eof - e0 != 0 || got_data.size() - d0 != 0) begin
      errors++; $display("FAIL abort_no_eof got eof %0d bytes %0d exp 0 0", n_eof - e0, got_data.size() - d0);
    end
    send_flag(); send_byte(8'h11); send_byte(8'h22); send_flag(); idle(2);
    checks++;
    if (got_data.size() - d0 != 2) begin errors++; $display("FAIL abort_recover_nbytes got %0d exp 2", got_data.size() - d0); end
    checks++;
    if (got_data[d0] !== 8'h11 || got_sof[d0] !== 1'b1 || got_data[d0+1] !== 8'h22) begin
      errors++; $display("FAIL abort_recover_bytes got %h/%b %h exp 11/1 22", got_data[d0], got_sof[d0], got_data[d0+1]);
    end
    checks++;
    if (n_eof - e0 != 1 || got_err[r0] !== 3'b000 || n_flag - f0 != 3 || n_abort - a0 != 1) begin
      errors++; $display("FAIL abort_recover_eof got eof %0d err %b flags %0d aborts %0d exp 1 000 3 1",
                         n_eof - e0, got_err[r0], n_flag - f0, n_abort - a0);
    end
  endtask

  task automatic test_short_frame();
    logic [11:0] v;
    int e0, d0, r0;
    e0 = n_eof; d0 = got_data.size(); r0 = got_err.size();
    v = 12'hA96;
    send_flag();
    for (int i = 0; i < 12; i++) send_data_bit(v[i]);
    send_flag(); idle(2);
    checks++;
    if (got_data.size() - d0 != 1 || got_data[d0] !== 8'h96 || got_sof[d0] !== 1'b1) begin
      errors++; $display("FAIL short_byte got n %0d %h sof %b exp 1 96 1", got_data.size() - d0, got_data[d0], got_sof[d0]);
    end
    checks++;
    if (n_eof - e0 != 1 || got_err[r0] !== 3'b011) begin
      errors++; $display("FAIL short_err got eof %0d err %b exp 1 011", n_eof - e0, got_err[r0]);
    end
  endtask

  task automatic test_fill();
    int f0, e0, d0;
    f0 = n_flag; e0 = n_eof; d0 = got_data.size();
    send_flag(); send_flag(); send_flag(); idle(2);
    checks++;
    if (n_flag - f0 != 3) begin errors++; $display("FAIL fill_nflag got %0d exp 3", n_flag - f0); end
    checks++;
    if (n_eof - e0 != 0 || got_data.size() - d0 != 0) begin
      errors++; $display("FAIL fill_quiet got eof %0d bytes %0d exp 0 0", n_eof - e0, got_data.size() - d0);
    end
  endtask

  task automatic test_rx_en_drop();
    int f0, e0, d0;
    f0 = n_flag; e0 = n_eof; d0 = got_data.size();
    send_flag(); send_byte(8'h77);
    for (int i = 0; i < 4; i++) send_data_bit(1'b0);
    rx_en = 1'b0; idle(2); rx_en = 1'b1;
    send_flag(); idle(2);
    checks++;
    if (n_flag - f0 != 2 || n_eof - e0 != 0 || got_data.size() - d0 != 0) begin
      errors++; $display("FAIL rx_en_drop got flags %0d eof %0d bytes %0d exp 2 0 0",
                         n_flag - f0, n_eof - e0, got_data.size() - d0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int f0, e0, d0;
    send_flag(); send_byte(8'h5A);
    for (int i = 0; i < 4; i++) send_data_bit(1'b1);
    #2 rst_n_i = 1'b0;
    #1;
    checks++;
    if ({shiftreg, flag_det, rx_abort, rx_data, rx_data_vld, rx_sof, rx_eof, rx_err} !== 31'd0) begin
      errors++;
      $display("FAIL midreset_outputs got %h exp 0", {shiftreg, flag_det, rx_abort, rx_data, rx_data_vld, rx_sof, rx_eof, rx_err});
    end
    @(negedge clk_i); rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    tx_ones = 0;
    f0 = n_flag; e0 = n_eof; d0 = got_data.size();
    send_flag(); idle(2);
    checks++;
    if (n_flag - f0 != 1 || n_eof - e0 != 0 || got_data.size() - d0 != 0) begin
      errors++; $display("FAIL midreset_after got flags %0d eof %0d bytes %0d exp 1 0 0",
                         n_flag - f0, n_eof - e0, got_data.size() - d0);
    end
  endtask

`ifdef HDLC_RX_FCS_CHECK_EN
  function automatic logic [15:0] tb_crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = {1'b0, r[15:1]} ^ 16'h8408;
      else             r = {1'b0, r[15:1]};
    end
    return r;
  endfunction

  task automatic test_fcs();
    logic [15:0] fcs;
    int r0;
    fcs = ~tb_crc_byte(tb_crc_byte(16'hFFFF, 8'h01), 8'h02);
    r0 = got_err.size();
    send_flag(); send_byte(8'h01); send_byte(8'h02);
    send_byte(fcs[7:0]); send_byte(fcs[15:8]); send_flag(); idle(2);
    checks++;
    if (got_err[r0] !== 3'b000) begin errors++; $display("FAIL fcs_good got %b exp 000", got_err[r0]); end
    send_byte(8'h03); send_byte(8'h02);
    send_byte(fcs[7:0]); send_byte(fcs[15:8]); send_flag(); idle(2);
    checks++;
    if (got_err[r0+1] !== 3'b100) begin errors++; $display("FAIL fcs_bad got %b exp 100", got_err[r0+1]); end
  endtask
`endif

  initial begin
    checks = 0; errors = 0; tx_ones = 0;
    n_flag = 0; n_flag_bad = 0; n_abort = 0; n_eof = 0; n_eof_bad = 0;
    test_reset();
    test_basic_frame();
    test_stuffing();
    test_abort();
    test_short_frame();
    test_fill();
    test_rx_en_drop();
`ifdef HDLC_RX_FCS_CHECK_EN
    test_fcs();
`endif
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
